// File: rtl/m1_dmem_port_pkg.sv
// Shared types and constants for the M1 data-memory access engine.
package m1_dmem_port_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned RD_W          = 5;
    localparam int unsigned MEM_OP_W      = 5;
    localparam int unsigned MEM_OP_ACCESS = 4;
    localparam int unsigned MEM_OP_STORE  = 3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [3:0]      wstrb;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // Access width from funct3; unused encodings behave as a full word.
    function automatic size_e f3_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            F3_W:        f3_size = SZ_W;
            default:     f3_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/m1_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module m1_load_align
    import m1_dmem_port_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic        signed_c;

    always_comb begin
        byte_c      = rdata[{off, 3'b000} +: 8];
        half_c      = off[1] ? rdata[31:16] : rdata[15:0];
        signed_c    = ~funct3[2];
        load_data_c = rdata;
        case (f3_size(funct3))
            SZ_B:    load_data_c = {{24{signed_c & byte_c[7]}}, byte_c};
            SZ_H:    load_data_c = {{16{signed_c & half_c[15]}}, half_c};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/m1_dmem_port.sv
// M1-stage memory access engine: one valid/ready request per op, load response
// alignment, and a pipeline stall until the access retires.
module m1_dmem_port
    import m1_dmem_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                is_a_inst,
    input  logic [MEM_OP_W-1:0] mem_op,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     store_data,
    input  logic [RD_W-1:0]     rd,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic                dmem_req_we,
    output logic [XLEN-1:0]     dmem_req_addr,
    output logic [3:0]          dmem_req_wstrb,
    output logic [XLEN-1:0]     dmem_req_wdata,
    input  logic                dmem_resp_valid,
    input  logic [XLEN-1:0]     dmem_resp_rdata,
    output logic                stall,
    output logic                load_valid,
    output logic [XLEN-1:0]     load_data,
    output logic [RD_W-1:0]     load_rd,
    output logic                misalign,
    output logic [XLEN-1:0]     misalign_addr,
    output logic                bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    dmem_req_t       req_q, req_d, new_req_c;
    logic            req_valid_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            killed_q, killed_d, kill_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            load_valid_d, misalign_d, bus_err_d;
    logic [XLEN-1:0] load_data_d, misalign_addr_d, aligned_c;
    logic [RD_W-1:0] load_rd_d;
    size_e           sz_c;
    logic            accept_c, misal_c;

    assign dmem_req_we    = req_q.we;
    assign dmem_req_addr  = req_q.addr;
    assign dmem_req_wstrb = req_q.wstrb;
    assign dmem_req_wdata = req_q.wdata;

    assign stall  = ((state_q == ST_IDLE) & accept_c) | (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign kill_c = killed_q | flush;

    m1_load_align u_align (
        .funct3      (f3_q),
        .off         (off_q),
        .rdata       (dmem_resp_rdata),
        .load_data_c (aligned_c)
    );

    // Decode the incoming op and build the lane-replicated request.
    always_comb begin
        sz_c            = f3_size(mem_op[2:0]);
        accept_c        = is_a_inst & mem_op[MEM_OP_ACCESS] & ~flush;
        misal_c         = ((sz_c == SZ_H) & addr[0]) | ((sz_c == SZ_W) & (addr[1:0] != 2'b00));
        new_req_c       = '0;
        new_req_c.we    = mem_op[MEM_OP_STORE];
        new_req_c.addr  = {addr[XLEN-1:2], 2'b00};
        if (mem_op[MEM_OP_STORE]) begin
            case (sz_c)
                SZ_B: begin
                    new_req_c.wstrb = 4'b0001 << addr[1:0];
                    new_req_c.wdata = {4{store_data[7:0]}};
                end
                SZ_H: begin
                    new_req_c.wstrb = 4'b0011 << addr[1:0];
                    new_req_c.wdata = {2{store_data[15:0]}};
                end
                default: begin
                    new_req_c.wstrb = 4'b1111;
                    new_req_c.wdata = store_data;
                end
            endcase
        end
    end

    // Next-state and next registered outputs.
    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        req_valid_d     = dmem_req_valid;
        f3_d            = f3_q;
        off_d           = off_q;
        rd_d            = rd_q;
        killed_d        = killed_q;
        cnt_d           = '0;
        load_valid_d    = 1'b0;
        load_data_d     = load_data;
        load_rd_d       = load_rd;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr;
        bus_err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                killed_d = 1'b0;
                if (accept_c) begin
                    if (misal_c) begin
                        state_d         = ST_DONE;
                        misalign_d      = 1'b1;
                        misalign_addr_d = addr;
                    end else begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        req_d       = new_req_c;
                        f3_d        = mem_op[2:0];
                        off_d       = addr[1:0];
                        rd_d        = rd;
                    end
                end
            end
            ST_REQ: begin
                killed_d = kill_c;
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = req_q.we ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                killed_d = kill_c;
                if (dmem_resp_valid) begin
                    state_d      = ST_DONE;
                    load_valid_d = ~kill_c;
                    if (!kill_c) begin
                        load_data_d = aligned_c;
                        load_rd_d   = rd_q;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_DONE;
                    bus_err_d = ~kill_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                killed_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            req_q          <= '0;
            dmem_req_valid <= 1'b0;
            f3_q           <= '0;
            off_q          <= '0;
            rd_q           <= '0;
            killed_q       <= 1'b0;
            cnt_q          <= '0;
            load_valid     <= 1'b0;
            load_data      <= '0;
            load_rd        <= '0;
            misalign       <= 1'b0;
            misalign_addr  <= '0;
            bus_err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            dmem_req_valid <= req_valid_d;
            f3_q           <= f3_d;
            off_q          <= off_d;
            rd_q           <= rd_d;
            killed_q       <= killed_d;
            cnt_q          <= cnt_d;
            load_valid     <= load_valid_d;
            load_data      <= load_data_d;
            load_rd        <= load_rd_d;
            misalign       <= misalign_d;
            misalign_addr  <= misalign_addr_d;
            bus_err        <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_m1_dmem_port.sv
// Bench for m1_dmem_port: vector table of single ops plus flush, timeout and reset sequences.
module tb_m1_dmem_port;

    localparam logic [4:0] OP_LB   = 5'b10000;
    localparam logic [4:0] OP_LH   = 5'b10001;
    localparam logic [4:0] OP_LW   = 5'b10010;
    localparam logic [4:0] OP_L011 = 5'b10011;
    localparam logic [4:0] OP_LBU  = 5'b10100;
    localparam logic [4:0] OP_LHU  = 5'b10101;
    localparam logic [4:0] OP_L111 = 5'b10111;
    localparam logic [4:0] OP_SB   = 5'b11000;
    localparam logic [4:0] OP_SH   = 5'b11001;
    localparam logic [4:0] OP_SW   = 5'b11010;
    localparam int NVEC = 17;

    logic        clk, rst, flush, is_a_inst;
    logic [4:0]  mem_op, rd;
    logic [31:0] addr, store_data;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        stall, load_valid, misalign, bus_err;
    logic [31:0] load_data, misalign_addr;
    logic [4:0]  load_rd;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_mis;
        logic [31:0] exp_ld;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } ld_exp_t;

    vec_t    vecs[NVEC];
    ld_exp_t sbq[$];
    ld_exp_t mon_e;
    int      checks = 0;
    int      errors = 0;

    m1_dmem_port #(.TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .is_a_inst       (is_a_inst),
        .mem_op          (mem_op),
        .addr            (addr),
        .store_data      (store_data),
        .rd              (rd),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .stall           (stall),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_rd         (load_rd),
        .misalign        (misalign),
        .misalign_addr   (misalign_addr),
        .bus_err         (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_req_valid"}, 32'(dmem_req_valid), 32'd0);
        chk({pfx, "_req_we"}, 32'(dmem_req_we), 32'd0);
        chk({pfx, "_req_addr"}, dmem_req_addr, 32'd0);
        chk({pfx, "_req_wstrb"}, 32'(dmem_req_wstrb), 32'd0);
        chk({pfx, "_req_wdata"}, dmem_req_wdata, 32'd0);
        chk({pfx, "_stall"}, 32'(stall), 32'd0);
        chk({pfx, "_load_valid"}, 32'(load_valid), 32'd0);
        chk({pfx, "_load_data"}, load_data, 32'd0);
        chk({pfx, "_load_rd"}, 32'(load_rd), 32'd0);
        chk({pfx, "_misalign"}, 32'(misalign), 32'd0);
        chk({pfx, "_misalign_addr"}, misalign_addr, 32'd0);
        chk({pfx, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    // Scoreboard: every load_valid pulse must match the oldest expected load.
    always @(negedge clk) begin
        #2;
        if (load_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_load_valid", 32'(load_valid), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("load_data", load_data, mon_e.data);
                chk("load_rd", 32'(load_rd), 32'(mon_e.rd));
            end
        end
    end

    // One op with ready always high and the response the cycle after the handshake.
    task automatic run_vec(input vec_t v, input int idx);
        int          stall_n = 0;
        bit          saw_req = 1'b0;
        bit          saw_mis = 1'b0;
        bit          resp_next = 1'b0;
        bit          done = 1'b0;
        logic [31:0] want_addr;
        want_addr = {v.addr[31:2], 2'b00};
        @(negedge clk);
        is_a_inst = 1'b1; mem_op = v.op; addr = v.addr; store_data = v.sd; rd = v.rd;
        flush = 1'b0; dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (stall) stall_n++;
            if (dmem_req_valid && !saw_req) begin
                saw_req = 1'b1;
                chk($sformatf("v%0d_req_we", idx), 32'(dmem_req_we), 32'(v.exp_we));
                chk($sformatf("v%0d_req_addr", idx), dmem_req_addr, want_addr);
                chk($sformatf("v%0d_req_wstrb", idx), 32'(dmem_req_wstrb), 32'(v.exp_wstrb));
                if (v.exp_we) chk($sformatf("v%0d_req_wdata", idx), dmem_req_wdata, v.exp_wdata);
                if (!v.exp_we) begin
                    sbq.push_back('{v.exp_ld, v.rd});
                    resp_next = 1'b1;
                end
            end
            if (misalign) begin
                saw_mis = 1'b1;
                chk($sformatf("v%0d_misalign_addr", idx), misalign_addr, v.addr);
            end
            if (!stall) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            dmem_resp_valid = resp_next;
            dmem_resp_rdata = resp_next ? v.rdata : $urandom();
            resp_next = 1'b0;
        end
        #2;
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_stall_cycles", idx), 32'(stall_n), 32'(v.exp_stall));
        chk($sformatf("v%0d_req_seen", idx), 32'(saw_req), 32'(v.exp_req));
        chk($sformatf("v%0d_misalign_seen", idx), 32'(saw_mis), 32'(v.exp_mis));
        chk($sformatf("v%0d_sb_drained", idx), 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  sc;
        bit  early;
        rst = 1'b1; flush = 1'b0; is_a_inst = 1'b0; mem_op = '0; addr = '0; store_data = '0;
        rd = '0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;

        vecs[0]  = '{OP_LW,   32'h100, 32'h0, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 3};
        vecs[1]  = '{OP_LB,   32'h103, 32'h0, 5'd6,  32'h80123456, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'hFFFFFF80, 3};
        vecs[2]  = '{OP_LBU,  32'h103, 32'h0, 5'd7,  32'h80123456, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h00000080, 3};
        vecs[3]  = '{OP_LH,   32'h102, 32'h0, 5'd8,  32'h80010000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'hFFFF8001, 3};
        vecs[4]  = '{OP_LHU,  32'h102, 32'h0, 5'd9,  32'h80010000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h00008001, 3};
        vecs[5]  = '{OP_LB,   32'h101, 32'h0, 5'd10, 32'h80123456, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h00000034, 3};
        vecs[6]  = '{OP_LHU,  32'h100, 32'h0, 5'd11, 32'h1234FFFF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0000FFFF, 3};
        vecs[7]  = '{OP_LH,   32'h100, 32'h0, 5'd12, 32'h1234FFFF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 3};
        vecs[8]  = '{OP_L111, 32'h108, 32'h0, 5'd13, 32'h12345678, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h12345678, 3};
        vecs[9]  = '{OP_SH,   32'h202, 32'h1234ABCD, 5'd0, 32'h0, 1'b1, 1'b1, 4'hC, 32'hABCDABCD, 1'b0, 32'h0, 2};
        vecs[10] = '{OP_SB,   32'h301, 32'h1234ABCD, 5'd0, 32'h0, 1'b1, 1'b1, 4'h2, 32'hCDCDCDCD, 1'b0, 32'h0, 2};
        vecs[11] = '{OP_SW,   32'h400, 32'h1234ABCD, 5'd0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h1234ABCD, 1'b0, 32'h0, 2};
        vecs[12] = '{OP_LW,   32'h101, 32'h0, 5'd1,  32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1};
        vecs[13] = '{OP_LH,   32'h103, 32'h0, 5'd2,  32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1};
        vecs[14] = '{OP_L011, 32'h102, 32'h0, 5'd3,  32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1};
        vecs[15] = '{OP_SW,   32'h402, 32'h55, 5'd0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1};
        vecs[16] = '{OP_LB,   32'h102, 32'h0, 5'd14, 32'h80123456, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h00000012, 3};

        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check_zero("post_reset");

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);
        @(negedge clk);
        is_a_inst = 1'b0;

        // Ops that must not be accepted.
        mem_op = OP_LW; addr = 32'h100;
        #1 chk("na_no_inst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        is_a_inst = 1'b1; mem_op = 5'b00010;
        #1 chk("na_no_access_stall", 32'(stall), 32'd0);
        chk("na_no_inst_req", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        mem_op = OP_LW; flush = 1'b1;
        #1 chk("na_flush_stall", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0; is_a_inst = 1'b0;
        #1 chk("na_flush_req", 32'(dmem_req_valid), 32'd0);

        // Ready low four cycles with flush in the second: request held, result killed.
        @(negedge clk);
        is_a_inst = 1'b1; mem_op = OP_LW; addr = 32'h700; rd = 5'd9;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        #1 chk("fl_idle_stall", 32'(stall), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            flush = (c == 2);
            dmem_req_ready = (c == 5);
            #1;
            chk($sformatf("fl_req_valid_c%0d", c), 32'(dmem_req_valid), 32'd1);
            chk($sformatf("fl_req_addr_c%0d", c), dmem_req_addr, 32'h700);
            chk($sformatf("fl_stall_c%0d", c), 32'(stall), 32'd1);
        end
        @(negedge clk);
        flush = 1'b0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h11111111;
        #1 chk("fl_wait_stall", 32'(stall), 32'd1);
        chk("fl_req_dropped", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        #1 chk("fl_done_stall", 32'(stall), 32'd0);
        chk("fl_no_load_valid", 32'(load_valid), 32'd0);
        chk("fl_no_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        is_a_inst = 1'b0;
        #1 chk("fl_back_idle", 32'(stall), 32'd0);

        // No response: bus_err after eight WAIT cycles.
        @(negedge clk);
        is_a_inst = 1'b1; mem_op = OP_LW; addr = 32'h500; rd = 5'd3;
        dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0;
        sc = 0; early = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c < 10) begin
                sc += int'(stall);
                early |= (bus_err | load_valid);
            end else if (c == 10) begin
                chk("to_bus_err", 32'(bus_err), 32'd1);
                chk("to_stall_done", 32'(stall), 32'd0);
                chk("to_no_load_valid", 32'(load_valid), 32'd0);
            end else begin
                chk("to_bus_err_pulse", 32'(bus_err), 32'd0);
                chk("to_idle", 32'(stall), 32'd0);
            end
            @(negedge clk);
            if (c == 10) is_a_inst = 1'b0;
        end
        chk("to_stall_cycles", 32'(sc), 32'd10);
        chk("to_no_early_pulse", 32'(early), 32'd0);

        // Reset while waiting for a response.
        dmem_req_ready = 1'b1;
        is_a_inst = 1'b1; mem_op = OP_LW; addr = 32'h600; rd = 5'd4;
        @(negedge clk);
        #1 chk("rw_req_valid", 32'(dmem_req_valid), 32'd1);
        @(negedge clk);
        #1 chk("rw_wait_stall", 32'(stall), 32'd1);
        @(negedge clk);
        rst = 1'b1; is_a_inst = 1'b0;
        @(negedge clk);
        #1 check_zero("rst_mid_wait");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rw_idle_after", 32'(dmem_req_valid), 32'd0);
        run_vec(vecs[0], 100);
        @(negedge clk);
        is_a_inst = 1'b0;

        @(negedge clk);
        #3 chk("sb_final_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m1_dmem_port.md
Name: m1_dmem_port

Overview:
- Memory-access engine for the M1 stage of the RISC pipeline. It consumes the E/M1 register outputs (mem_op, result as address, operand2 as store data, rd).
- Issues one valid/ready request to data memory and waits for the load response. Aligns and extends load data.
- Holds the front of the pipeline via stall until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before bus_err; 0 disables timeout.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
flush  input  1  kill current M1 op
is_a_inst  input  1  M1 slot holds a real instruction
mem_op  input  5  [4]=mem access, [3]=store(1)/load(0), [2:0]=funct3 (B=000,H=001,W=010,BU=100,HU=101)
addr  input  32  byte address (E-stage result)
store_data  input  32  rs2 value (operand2)
rd  input  5  load destination
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts request
dmem_req_we  output  1  1=write
dmem_req_addr  output  32  word address, {addr[31:2],2'b00}
dmem_req_wstrb  output  4  byte enables (0 for loads)
dmem_req_wdata  output  32  lane-replicated store data
dmem_resp_valid  input  1  read data valid
dmem_resp_rdata  input  32  read word
stall  output  1  hold IF..M1
load_valid  output  1  1-cycle pulse, load_data valid
load_data  output  32  aligned/extended load result
load_rd  output  5  rd of completed load
misalign  output  1  1-cycle pulse, misaligned access
misalign_addr  output  32  offending address
bus_err  output  1  1-cycle pulse, response timeout

Behaviour:
- Reset: all outputs 0; FSM=IDLE; timeout counter=0. Applies mid-operation as well: any outstanding request is abandoned, and memory is reset on the same rst.
- Op accepted when is_a_inst & mem_op[4] & !flush in IDLE.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- stall is combinational: 1 in IDLE when an op is accepted, and 1 in REQ and WAIT. 0 in DONE.
- FSM:
  - IDLE: op accepted and misaligned -> DONE, with misalign=1 and misalign_addr=addr in DONE. Op accepted and aligned -> REQ; request fields registered.
  - REQ: dmem_req_valid=1 and fields stable until dmem_req_ready. On handshake, store -> DONE and load -> WAIT.
  - WAIT: on dmem_resp_valid, capture the extended data -> DONE. The earliest response is the cycle after the handshake. Counter increments each WAIT cycle; at TIMEOUT_CYCLES -> DONE with bus_err=1 and load_valid=0.
  - DONE: single cycle. load_valid=1 for a completed un-killed load; stall=0 so the pipeline advances. Inputs are ignored this cycle. Next state IDLE.
- Flush:
  - In IDLE: no op accepted.
  - In REQ or WAIT: the op is marked killed. req_valid is never withdrawn before ready; the response is still consumed. DONE gives no load_valid, misalign or bus_err.
- Store data (off=addr[1:0]):
  - SB: wdata={4{sd[7:0]}}, wstrb=0001<<off.
  - SH: wdata={2{sd[15:0]}}, wstrb=0011<<off.
  - SW: wdata=sd, wstrb=1111.
- Load data: select byte rdata[8*off+:8] or half rdata[16*off[1]+:16]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Unused funct3 codes are treated as W width.
- Minimum latency: aligned load 3 stall cycles + DONE; store 2 stall cycles + DONE; misaligned 1 stall cycle + DONE.

Decomposition:
- Shared package holds the MEM_OP bit positions, the funct3 width constants and the FSM state enum (IDLE, REQ, WAIT, DONE).
- One sub-module, m1_load_align: combinational byte/half select and sign/zero extension of the response word.

Test Plan:
- LW addr 0x100, ready=1, resp 0xDEADBEEF the cycle after the handshake -> stall high cycles 0-2; cycle 3 load_valid=1, load_data=0xDEADBEEF, load_rd=rd.
- LB/LBU addr 0x103, rdata 0x80123456 -> 0xFFFFFF80 / 0x00000080; LH addr 0x102, rdata 0x8001_0000 -> 0xFFFF8001.
- SH addr 0x202, store_data 0x1234ABCD -> req_we=1, req_addr=0x200, wstrb=1100, wdata=0xABCDABCD; DONE on the cycle after the handshake, no wait for a response.
- LW addr 0x101 -> misalign=1, misalign_addr=0x101, dmem_req_valid never asserted, stall high exactly 1 cycle.
- LW with ready low for 4 cycles and flush in the 2nd -> req_valid held, addr stable; response consumed, load_valid stays 0.
- TIMEOUT_CYCLES=8, no response -> bus_err pulse after 8 WAIT cycles, then IDLE. rst during WAIT -> next cycle IDLE, all outputs 0.
